// File: rtl/rsa_pkg.sv
// Shared RSA octet/integer conversion definitions: widths and the conversion FSM state set.
// Used by both the I2OSP serializer and the OS2IP block.
package rsa_pkg;

   localparam int DATA_BIT_WIDTH = 256;
   localparam int NBYTES         = DATA_BIT_WIDTH / 8;
   localparam int LEN_W          = $clog2(NBYTES) + 1;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SEND,
      DONE,
      ERR
   } rsa_state_e;

   // Width of an octet-length field able to hold the full octet count of a bit_width integer.
   function automatic int octet_len_w(input int bit_width);
      return $clog2(bit_width / 8) + 1;
   endfunction

endpackage

// File: rtl/i2osp_serializer_if.sv
// Request/octet-stream bundle between an upstream requester (master) and the serializer (slave).
interface i2osp_serializer_if
   import rsa_pkg::*;
#(
   parameter int DATA_BIT_WIDTH = rsa_pkg::DATA_BIT_WIDTH,
   parameter int LEN_W          = rsa_pkg::octet_len_w(DATA_BIT_WIDTH)
) ();

   logic [DATA_BIT_WIDTH-1:0] x;
   logic [LEN_W-1:0]          xlen;
   logic                      in_valid;
   logic                      in_ready;
   logic [7:0]                out_byte;
   logic                      out_valid;
   logic                      out_ready;
   logic                      out_last;
   logic                      done;
   logic                      error;

   modport master (
      output x, xlen, in_valid, out_ready,
      input  in_ready, out_byte, out_valid, out_last, done, error
   );

   modport slave (
      input  x, xlen, in_valid, out_ready,
      output in_ready, out_byte, out_valid, out_last, done, error
   );

endinterface

// File: rtl/i2osp_range_check.sv
// Combinational reject decision for an I2OSP request: illegal length or an integer
// that does not fit in i_xlen octets.
module i2osp_range_check
   import rsa_pkg::*;
#(
   parameter int DATA_BIT_WIDTH = rsa_pkg::DATA_BIT_WIDTH,
   parameter int LEN_W          = rsa_pkg::octet_len_w(DATA_BIT_WIDTH)
) (
   input  logic [DATA_BIT_WIDTH-1:0] i_x,
   input  logic [LEN_W-1:0]          i_xlen,
   output logic                      o_too_large
);

   localparam int NB = DATA_BIT_WIDTH / 8;

   logic [LEN_W+2:0] w_shamt;

   assign w_shamt = {i_xlen, 3'b000};

   // Lengths above NB shift everything out, so the magnitude test alone would pass them.
   always_comb begin
      o_too_large = 1'b0;
      if (i_xlen == '0 || i_xlen > LEN_W'(NB)) begin
         o_too_large = 1'b1;
      end else if ((i_x >> w_shamt) != '0) begin
         o_too_large = 1'b1;
      end
   end

endmodule

// File: rtl/i2osp_serializer.sv
// PKCS#1 I2OSP: turns an integer into an xlen-octet big-endian string, one octet per
// out_valid/out_ready handshake, with a done pulse on completion or an error pulse on reject.
module i2osp_serializer
   import rsa_pkg::*;
#(
   parameter int DATA_BIT_WIDTH = rsa_pkg::DATA_BIT_WIDTH,
   parameter int LEN_W          = rsa_pkg::octet_len_w(DATA_BIT_WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   i2osp_serializer_if.slave  bus
);

   // state | meaning
   // IDLE  | ready for a request; x/xlen captured on accept
   // CHECK | range check of the captured request, shift register loaded
   // SEND  | top byte of shift register presented until accepted
   // DONE  | one-cycle completion pulse
   // ERR   | one-cycle reject pulse, no octets emitted

   localparam int NB = DATA_BIT_WIDTH / 8;

   rsa_state_e                r_state;
   rsa_state_e                w_state_nxt;
   logic [DATA_BIT_WIDTH-1:0] r_x;
   logic [LEN_W-1:0]          r_xlen;
   logic [DATA_BIT_WIDTH-1:0] r_shift;
   logic [LEN_W-1:0]          r_remaining;
   logic                      w_too_large;
   logic [LEN_W+2:0]          w_lshamt;
   logic                      w_last;

   i2osp_range_check #(
      .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
      .LEN_W          (LEN_W)
   ) u_range_check (
      .i_x         (r_x),
      .i_xlen      (r_xlen),
      .o_too_large (w_too_large)
   );

   // Left-justify so octet xlen-1 lands in the top byte; only used when xlen is legal.
   assign w_lshamt = {LEN_W'(NB) - r_xlen, 3'b000};
   assign w_last   = (r_remaining == LEN_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_byte  = 8'h00;
      bus.done      = 1'b0;
      bus.error     = 1'b0;
      case (r_state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               w_state_nxt = CHECK;
            end
         end
         CHECK: begin
            w_state_nxt = w_too_large ? ERR : SEND;
         end
         SEND: begin
            bus.out_valid = 1'b1;
            bus.out_byte  = r_shift[DATA_BIT_WIDTH-1 -: 8];
            bus.out_last  = w_last;
            if (bus.out_ready && w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            bus.done    = 1'b1;
            w_state_nxt = IDLE;
         end
         ERR: begin
            bus.error   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_x         <= '0;
         r_xlen      <= '0;
         r_shift     <= '0;
         r_remaining <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_x    <= bus.x;
                  r_xlen <= bus.xlen;
               end
            end
            CHECK: begin
               if (!w_too_large) begin
                  r_shift     <= r_x << w_lshamt;
                  r_remaining <= r_xlen;
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  r_shift     <= {r_shift[DATA_BIT_WIDTH-9:0], 8'h00};
                  r_remaining <= r_remaining - LEN_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2osp_serializer.sv
// Self-checking bench for i2osp_serializer: directed cases plus random requests
// against a divide-by-256 reference model.
module tb_i2osp_serializer;
   import rsa_pkg::*;

   localparam int NB = NBYTES;

   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;

   i2osp_serializer_if bus ();

   i2osp_serializer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // mode 0: out_ready always 1; mode 1: alternating 0/1 from cycle 2; mode 2: random
   task automatic do_req(input logic [255:0] x, input int len, input int mode);
      logic [7:0]   exp_q[$];
      logic [255:0] tmp;
      bit           exp_err;
      bit           finished;
      bit           prev_stall;
      logic [7:0]   prev_byte;
      logic         prev_last;
      int           cyc, nvalid, first_cyc, done_cyc, err_cyc, rdy_cyc, k;

      exp_err = (len < 1 || len > NB);
      tmp = x;
      if (!exp_err) begin
         for (int i = 0; i < len; i++) begin
            exp_q.push_front(8'(tmp % 256));
            tmp = tmp / 256;
         end
         if (tmp != 0) exp_err = 1'b1;
      end
      if (exp_err) exp_q.delete();

      @(negedge clk);
      k = 0;
      while (!bus.in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!bus.in_ready) chk("idle_wait", 0, 1);

      bus.x        = x;
      bus.xlen     = 6'(len);
      bus.in_valid = 1'b1;
      bus.out_ready = (mode == 0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.x        = {8{$urandom}};
      bus.xlen     = 6'($urandom);

      cyc = 1; nvalid = 0; first_cyc = -1; done_cyc = -1; err_cyc = -1; rdy_cyc = -1;
      finished = 1'b0; prev_stall = 1'b0; prev_byte = 8'h00; prev_last = 1'b0;
      while (!finished && cyc < 400) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 2 == 1);
            default: bus.out_ready = 1'($urandom % 2);
         endcase
         if (prev_stall) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_byte", bus.out_byte, prev_byte);
            chk("hold_last", bus.out_last, prev_last);
         end
         if (bus.out_valid) begin
            nvalid++;
            if (first_cyc < 0) first_cyc = cyc;
            if (bus.out_ready) begin
               if (exp_q.size() > 0) begin
                  chk("byte", bus.out_byte, exp_q.pop_front());
                  chk("last", bus.out_last, exp_q.size() == 0);
               end else begin
                  chk("extra_byte", bus.out_byte, 256'h1_00);
               end
            end
         end
         if (bus.done) begin
            done_cyc = cyc;
            chk("done_excl", {bus.out_valid, bus.error}, 0);
         end
         if (bus.error) begin
            err_cyc = cyc;
            chk("err_excl", {bus.out_valid, bus.done}, 0);
         end
         if ((done_cyc >= 0 || err_cyc >= 0) && bus.in_ready) begin
            finished = 1'b1;
            rdy_cyc  = cyc;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_byte  = bus.out_byte;
         prev_last  = bus.out_last;
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.out_ready = 1'b0;

      chk("finished", finished, 1);
      chk("err_flag", err_cyc >= 0, exp_err);
      chk("bytes_left", exp_q.size(), 0);
      if (exp_err) begin
         chk("err_nvalid", nvalid, 0);
         chk("err_cyc", err_cyc, 2);
         chk("err_rdy_cyc", rdy_cyc, 3);
      end else begin
         chk("nvalid_min", nvalid >= len, 1);
         if (mode == 0) begin
            chk("first_cyc", first_cyc, 2);
            chk("done_cyc", done_cyc, len + 2);
            chk("rdy_cyc", rdy_cyc, len + 3);
         end
      end
   endtask

   initial begin
      logic [255:0] rx;
      int           rlen;
      n_total = 0;
      n_pass  = 0;
      reset         = 1'b1;
      bus.x         = '0;
      bus.xlen      = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_outs", {bus.out_valid, bus.out_last, bus.done, bus.error, bus.out_byte}, 0);
      reset = 1'b0;

      do_req(256'h0102, 2, 0);
      do_req(256'h0102, 4, 0);
      do_req(256'h010000, 2, 0);
      do_req(256'h5, 0, 0);
      do_req(256'h5, 33, 0);
      do_req({256{1'b1}}, 32, 0);
      do_req({256{1'b1}}, 31, 0);
      do_req(256'hA1B2C3, 3, 1);

      // Reset while streaming: abandon after the first octet.
      @(negedge clk);
      bus.x = 256'h11223344; bus.xlen = 6'd4; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_b0", {bus.out_valid, bus.out_byte}, {1'b1, 8'h11});
      @(negedge clk);
      chk("rst_mid_b1", {bus.out_valid, bus.out_byte}, {1'b1, 8'h22});
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_rdy", bus.in_ready, 1);
      chk("rst_mid_outs", {bus.out_valid, bus.out_last, bus.done, bus.error, bus.out_byte}, 0);
      reset = 1'b0;
      bus.out_ready = 1'b0;
      do_req(256'h55, 1, 0);

      for (int i = 0; i < 30; i++) begin
         for (int w = 0; w < 8; w++) rx[w*32 +: 32] = $urandom;
         rlen = (($urandom % 8) == 0) ? int'($urandom % 40) : 1 + int'($urandom % NB);
         if (($urandom % 4) != 0 && rlen <= NB) rx = rx & ((256'b1 << (8 * rlen)) - 1);
         if (($urandom % 3) == 0) rx = rx >> (8 * ($urandom % 32));
         do_req(rx, rlen, int'($urandom % 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/i2osp_serializer.md
# i2osp_serializer

Converts a nonnegative integer into an xLen-octet string per PKCS#1 I2OSP, the inverse of the team's octet-string-to-integer block. It sits on the RSA output path after modular exponentiation and streams the big-endian octets one byte per handshake toward the network/packet framing logic. It rejects integers too large for the requested length and signals that with an error pulse.

## Interface
- DATA_BIT_WIDTH, 256: integer width in bits. Must be a multiple of 8. NBYTES = DATA_BIT_WIDTH/8.
- LEN_W, $clog2(NBYTES)+1: width of `xlen`.

- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- x  input  DATA_BIT_WIDTH  nonnegative integer to encode
- xlen  input  LEN_W  requested octet-string length; legal range 1..NBYTES
- in_valid  input  1  `x` and `xlen` are valid
- in_ready  output  1  block can accept a request; high only in IDLE
- out_byte  output  8  current octet, most significant first
- out_valid  output  1  `out_byte` is valid
- out_ready  input  1  downstream accepts `out_byte`
- out_last  output  1  marks the final octet; qualified by `out_valid`
- done  output  1  one-cycle pulse after the last octet is accepted
- error  output  1  one-cycle pulse: "integer too large", or `xlen` illegal

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
    - On `in_valid & in_ready`, register `x` and `xlen` and go to CHECK.
  - CHECK (1 cycle):
    - Bad when `xlen==0`, `xlen>NBYTES`, or `(x >> 8*xlen) != 0`.
    - Bad goes to ERR. Otherwise go to SEND.
    - On the way to SEND, load the shift register with `x << 8*(NBYTES-xlen)`, so octet xlen-1 is in the top byte.
    - Load the remaining-count with `xlen`.
  - SEND:
    - `out_byte` = top byte of the shift register.
    - `out_valid`=1.
    - `out_last` = (remaining==1).
    - On `out_valid & out_ready`: shift left 8, decrement remaining. If it was last, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
  - ERR: `error`=1 for one cycle, then IDLE. No octet is ever emitted for a rejected request.
- Output order is octet X_1 first. X_1 = x div 256^(xlen-1) mod 256, down to x mod 256.
- Leading octets are zero when x < 256^(xlen-1).
- While `out_valid` is high and `out_ready` is low, `out_byte` and `out_last` hold stable.
- The input is sampled only at the accept edge. Later changes to `x`/`xlen` have no effect.
- `in_valid` while busy is ignored, because `in_ready`=0. There is no queuing.

## Timing
- Reset:
  - state = IDLE.
  - `in_ready`=1; `out_valid`, `out_last`, `done`, `error` = 0.
  - `out_byte`=0; internal registers cleared.
- Reset mid-operation:
  - Aborts the transfer. All outputs take reset values in the cycle after the reset edge.
  - The partial string is abandoned; no `done` or `error` pulse.
- Cycle numbering, with cycle 0 = accept edge:
  - Cycle 1: CHECK.
  - Cycle 2: first octet valid, or `error`=1.
  - After an error: `in_ready`=1 at cycle 3.
- No backpressure: octet k is valid in cycle 2+k.
  - Last octet in cycle xlen+1, `done` in cycle xlen+2, `in_ready` in cycle xlen+3.
  - Throughput: one request per xlen+3 cycles.
- `done` and `error` are never high together. Neither coincides with `out_valid`.
- `in_ready` is a decode of state only. It never depends combinationally on `in_valid`.
- `out_valid` does not depend combinationally on `out_ready`.

## Structure
- Shared package `rsa_pkg`:
  - DATA_BIT_WIDTH default; NBYTES and LEN_W derivations.
  - FSM state enum {IDLE, CHECK, SEND, DONE, ERR}.
  - The same package serves the octet-string-to-integer block.
- One natural sub-module, `i2osp_range_check`: combinational; takes x and xlen; outputs `too_large`.
- The shift register, counter and FSM stay in the top module.

## Test plan
- x=0x0102, xlen=2, out_ready=1 -> bytes 0x01, 0x02 in cycles 2–3; `out_last` with 0x02; `done` in cycle 4.
- x=0x0102, xlen=4 -> 0x00, 0x00, 0x01, 0x02; `out_last` on the 4th byte.
- Rejected requests -> `error` pulse in cycle 2, zero `out_valid` cycles, `in_ready`=1 in cycle 3:
  - x=0x010000, xlen=2.
  - xlen=0.
  - xlen=33.
- x=all-ones (256 bits), xlen=32, out_ready=1 -> 32 bytes of 0xFF; `done` in cycle 34.
- x=0xA1B2C3, xlen=3, out_ready alternating 0/1 from cycle 2 -> each byte held stable while stalled; sequence A1, B2, C3 with no duplicates or drops.
- Reset asserted during SEND after the first byte (x=0x11223344, xlen=4) -> next cycle: `out_valid`=0 and `in_ready`=1. Then a new request x=0x55, xlen=1 -> single byte 0x55 with `out_last`.
